// File: rtl/pico_pkg.sv
// Shared opcode map, ALU codes, control-word layout and FSM state type for the
// sequenced instruction decoder.
package pico_pkg;

    localparam int OPW_DEF = 6;

    localparam logic [OPW_DEF-1:0] NOP  = 6'd0;
    localparam logic [OPW_DEF-1:0] ADD  = 6'd1;
    localparam logic [OPW_DEF-1:0] ADDI = 6'd2;
    localparam logic [OPW_DEF-1:0] MUL  = 6'd3;
    localparam logic [OPW_DEF-1:0] MULI = 6'd4;
    localparam logic [OPW_DEF-1:0] DISP = 6'd5;
    localparam logic [OPW_DEF-1:0] ADDF = 6'd6;
    localparam logic [OPW_DEF-1:0] BREL = 6'd7;
    localparam logic [OPW_DEF-1:0] BABS = 6'd8;

    localparam logic [2:0] RNOP = 3'd0;
    localparam logic [2:0] RADD = 3'd1;
    localparam logic [2:0] RMUL = 3'd2;

    typedef enum logic [1:0] {DEC, MULW, RDYW} dec_state_t;

    // Field order matters: the bench packs DUT outputs in this same order.
    typedef struct packed {
        logic       pc_incr;
        logic       pc_absbranch;
        logic       pc_relbranch;
        logic [2:0] alu_func;
        logic       imm;
        logic       w;
        logic       store;
        logic       disp;
        logic       busy;
    } ctl_t;

    function automatic ctl_t ctl_idle();
        ctl_t c;
        c          = '0;
        c.alu_func = RNOP;
        return c;
    endfunction

endpackage

// File: rtl/dec_comb.sv
// Single-cycle opcode-to-control lookup; MUL/MULI decode as a one-cycle
// multiply and BREL as a fall-through, the sequencer overrides both.
module dec_comb
    import pico_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] opcode,
    output ctl_t           ctl
);

    // NOTE: every field gets a default before the case so no latch is inferred.
    always_comb begin
        ctl         = ctl_idle();
        ctl.pc_incr = 1'b1;
        case (opcode)
            ADD: begin
                ctl.w        = 1'b1;
                ctl.alu_func = RADD;
            end
            ADDI: begin
                ctl.w        = 1'b1;
                ctl.imm      = 1'b1;
                ctl.alu_func = RADD;
            end
            DISP: begin
                ctl.disp     = 1'b1;
                ctl.alu_func = RADD;
            end
            ADDF: begin
                ctl.store    = 1'b1;
                ctl.alu_func = RADD;
            end
            BABS: begin
                ctl.pc_absbranch = 1'b1;
                ctl.pc_incr      = 1'b0;
            end
            MUL, MULI: begin
                ctl.w        = 1'b1;
                ctl.alu_func = RMUL;
                ctl.imm      = (opcode == MULI);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_decoder.sv
// Multi-cycle instruction decoder: stalls the PC for multi-cycle multiplies and
// for BREL waiting on ready, otherwise defers to the single-cycle lookup.
module seq_decoder
    import pico_pkg::*;
#(
    parameter int OPW       = OPW_DEF,
    parameter int NFLAGS    = 4,
    parameter int MUL_LAT   = 3,
    parameter int BREL_WAIT = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic [NFLAGS-1:0] flags,
    input  logic              ready,
    input  logic              br_cond,
    output logic              pc_incr,
    output logic              pc_absbranch,
    output logic              pc_relbranch,
    output logic [2:0]        ALUfunc,
    output logic              imm,
    output logic              w,
    output logic              store,
    output logic              disp,
    output logic              busy
);

    localparam int CNT_MAX = (MUL_LAT > TIMEOUT) ? MUL_LAT : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    dec_state_t     state, next_state;
    logic [CW-1:0]  cnt, next_cnt;
    logic [OPW-1:0] op_q;
    ctl_t           dec_ctl, ctl;

    logic unused_flags;
    assign unused_flags = ^flags;

    dec_comb #(.OPW(OPW)) u_dec_comb (
        .opcode (opcode),
        .ctl    (dec_ctl)
    );

    logic match, is_mul, mul_last, rdy_timeout;
    assign match       = (ready == br_cond);
    assign is_mul      = (opcode == MUL) || (opcode == MULI);
    assign mul_last    = (cnt == CW'(MUL_LAT - 1));
    assign rdy_timeout = (cnt == CW'(TIMEOUT));

    always_comb begin
        ctl        = ctl_idle();
        next_state = DEC;
        next_cnt   = '0;
        if (!reset) begin
            case (state)
                DEC: begin
                    ctl = dec_ctl;
                    if (is_mul && (MUL_LAT > 1)) begin
                        ctl.w       = 1'b0;
                        ctl.pc_incr = 1'b0;
                        ctl.busy    = 1'b1;
                        next_state  = MULW;
                        next_cnt    = CW'(1);
                    end else if (opcode == BREL) begin
                        if (match) begin
                            ctl.pc_incr      = 1'b0;
                            ctl.pc_relbranch = 1'b1;
                        end else if (BREL_WAIT != 0) begin
                            ctl.pc_incr = 1'b0;
                            ctl.busy    = 1'b1;
                            next_state  = RDYW;
                            next_cnt    = CW'(1);
                        end
                    end
                end
                MULW: begin
                    ctl.alu_func = RMUL;
                    ctl.imm      = (op_q == MULI);
                    ctl.busy     = 1'b1;
                    if (mul_last) begin
                        ctl.w       = 1'b1;
                        ctl.pc_incr = 1'b1;
                    end else begin
                        next_state = MULW;
                        next_cnt   = cnt + CW'(1);
                    end
                end
                RDYW: begin
                    ctl.busy = 1'b1;
                    // A ready match wins over a timeout landing in the same cycle.
                    if (match) begin
                        ctl.pc_relbranch = 1'b1;
                    end else if (rdy_timeout) begin
                        ctl.pc_incr = 1'b1;
                    end else begin
                        next_state = RDYW;
                        next_cnt   = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DEC;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (state == DEC && next_state != DEC)
                op_q <= opcode;
        end
    end

    assign pc_incr      = ctl.pc_incr;
    assign pc_absbranch = ctl.pc_absbranch;
    assign pc_relbranch = ctl.pc_relbranch;
    assign ALUfunc      = ctl.alu_func;
    assign imm          = ctl.imm;
    assign w            = ctl.w;
    assign store        = ctl.store;
    assign disp         = ctl.disp;
    assign busy         = ctl.busy;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: directed vector table, hand-written multi-cycle
// sequences, then random stimulus against a per-instruction reference model.
module tb_seq_decoder;
    import pico_pkg::*;

    localparam int TIMEOUT = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [3:0] flags = '0;
    logic       ready = 1'b0;
    logic       br_cond = 1'b0;

    logic       pi0, pa0, pr0, im0, w0, st0, di0, bz0;
    logic [2:0] alu0;
    logic       pi1, pa1, pr1, im1, w1, st1, di1, bz1;
    logic [2:0] alu1;
    ctl_t       obs0, obs1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    seq_decoder #(.OPW(6), .NFLAGS(4), .MUL_LAT(3), .BREL_WAIT(1), .TIMEOUT(TIMEOUT)) u_dut0 (
        .clock(clock), .reset(reset), .opcode(opcode), .flags(flags), .ready(ready),
        .br_cond(br_cond), .pc_incr(pi0), .pc_absbranch(pa0), .pc_relbranch(pr0),
        .ALUfunc(alu0), .imm(im0), .w(w0), .store(st0), .disp(di0), .busy(bz0)
    );

    seq_decoder #(.OPW(6), .NFLAGS(4), .MUL_LAT(1), .BREL_WAIT(0), .TIMEOUT(TIMEOUT)) u_dut1 (
        .clock(clock), .reset(reset), .opcode(opcode), .flags(flags), .ready(ready),
        .br_cond(br_cond), .pc_incr(pi1), .pc_absbranch(pa1), .pc_relbranch(pr1),
        .ALUfunc(alu1), .imm(im1), .w(w1), .store(st1), .disp(di1), .busy(bz1)
    );

    assign obs0 = {pi0, pa0, pr0, alu0, im0, w0, st0, di0, bz0};
    assign obs1 = {pi1, pa1, pr1, alu1, im1, w1, st1, di1, bz1};

    always @(negedge clock) begin
        #2;
        n_tests++;
        assert ($onehot0({pi0, pa0, pr0}) && $onehot0({pi1, pa1, pr1})) else begin
            n_fail++;
            $display("FAIL pc_mutex: got dut0=%b dut1=%b, required at most one hot",
                     {pi0, pa0, pr0}, {pi1, pa1, pr1});
        end
    end

    task automatic check(input string name, input ctl_t got, input ctl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (pi pa pr alu imm w st di busy)", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle well before the next rise.
    task automatic step(input logic r, input logic [5:0] op, input logic rdy, input logic bc);
        @(negedge clock);
        reset   = r;
        opcode  = op;
        ready   = rdy;
        br_cond = bc;
        flags   = 4'($urandom);
        #1;
    endtask

    function automatic ctl_t mk(input logic pi, input logic pa, input logic pr, input logic [2:0] alu,
                                input logic i, input logic wr, input logic st, input logic di,
                                input logic bz);
        mk = {pi, pa, pr, alu, i, wr, st, di, bz};
    endfunction

    // Reference: k is the cycle index within the current instruction.
    function automatic ctl_t model(input int k, input logic [5:0] op, input logic rdy, input logic bc,
                                   input logic rst, input int mul_lat, input int brel_wait,
                                   output logic done);
        ctl_t e;
        e    = '0;
        e.alu_func = RNOP;
        done = 1'b1;
        if (rst) return e;
        case (op)
            ADD:  begin e.pc_incr = 1; e.w = 1; e.alu_func = RADD; end
            ADDI: begin e.pc_incr = 1; e.w = 1; e.imm = 1; e.alu_func = RADD; end
            DISP: begin e.pc_incr = 1; e.disp = 1; e.alu_func = RADD; end
            ADDF: begin e.pc_incr = 1; e.store = 1; e.alu_func = RADD; end
            BABS: e.pc_absbranch = 1;
            MUL, MULI: begin
                e.alu_func = RMUL;
                e.imm      = (op == MULI);
                e.busy     = (mul_lat > 1);
                done       = (k == mul_lat - 1);
                e.w        = done;
                e.pc_incr  = done;
            end
            BREL: begin
                if (rdy == bc)           e.pc_relbranch = 1;
                else if (brel_wait == 0) e.pc_incr = 1;
                else if (k == TIMEOUT)   e.pc_incr = 1;
                else                     done = 1'b0;
                e.busy = (k > 0) || !done;
            end
            default: e.pc_incr = 1;
        endcase
        return e;
    endfunction

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic       bc;
        ctl_t       exp;
    } vec_t;

    vec_t vecs[21];

    initial begin
        int   k0, k1;
        logic [5:0] cur0, cur1, op_r;
        logic d0, d1, r_r, rdy_r, bc_r;
        ctl_t e0, e1;

        vecs[0]  = '{1, ADD,   0, 0, mk(0,0,0,RNOP,0,0,0,0,0)};
        vecs[1]  = '{0, ADD,   0, 0, mk(1,0,0,RADD,0,1,0,0,0)};
        vecs[2]  = '{0, ADDI,  0, 0, mk(1,0,0,RADD,1,1,0,0,0)};
        vecs[3]  = '{0, DISP,  0, 0, mk(1,0,0,RADD,0,0,0,1,0)};
        vecs[4]  = '{0, ADDF,  0, 0, mk(1,0,0,RADD,0,0,1,0,0)};
        vecs[5]  = '{0, NOP,   0, 0, mk(1,0,0,RNOP,0,0,0,0,0)};
        vecs[6]  = '{0, MULI,  0, 0, mk(0,0,0,RMUL,1,0,0,0,1)};
        vecs[7]  = '{0, ADD,   0, 0, mk(0,0,0,RMUL,1,0,0,0,1)};
        vecs[8]  = '{0, NOP,   0, 0, mk(1,0,0,RMUL,1,1,0,0,1)};
        vecs[9]  = '{0, BABS,  0, 0, mk(0,1,0,RNOP,0,0,0,0,0)};
        vecs[10] = '{0, 6'd63, 0, 0, mk(1,0,0,RNOP,0,0,0,0,0)};
        vecs[11] = '{0, BREL,  1, 1, mk(0,0,1,RNOP,0,0,0,0,0)};
        vecs[12] = '{0, MUL,   0, 0, mk(0,0,0,RMUL,0,0,0,0,1)};
        vecs[13] = '{1, MUL,   0, 0, mk(0,0,0,RNOP,0,0,0,0,0)};
        vecs[14] = '{0, ADD,   0, 0, mk(1,0,0,RADD,0,1,0,0,0)};
        vecs[15] = '{0, BREL,  0, 1, mk(0,0,0,RNOP,0,0,0,0,1)};
        vecs[16] = '{0, BREL,  0, 1, mk(0,0,0,RNOP,0,0,0,0,1)};
        vecs[17] = '{0, BREL,  0, 1, mk(0,0,0,RNOP,0,0,0,0,1)};
        vecs[18] = '{0, BREL,  0, 1, mk(0,0,0,RNOP,0,0,0,0,1)};
        vecs[19] = '{0, BREL,  1, 1, mk(0,0,1,RNOP,0,0,0,0,1)};
        vecs[20] = '{0, NOP,   0, 0, mk(1,0,0,RNOP,0,0,0,0,0)};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].bc);
            check($sformatf("vec%0d", i), obs0, vecs[i].exp);
        end

        // BREL timeout: ready never matches; fall through exactly on wait cycle 15.
        for (int k = 0; k <= TIMEOUT; k++) begin
            step(0, BREL, 0, 1);
            check($sformatf("timeout_c%0d", k), obs0,
                  (k < TIMEOUT) ? mk(0,0,0,RNOP,0,0,0,0,1) : mk(1,0,0,RNOP,0,0,0,0,1));
        end
        step(0, NOP, 0, 1);
        check("timeout_after", obs0, mk(1,0,0,RNOP,0,0,0,0,0));

        // Single-sample BREL and single-cycle multiply instance.
        step(1, NOP, 0, 0);
        check("d1_reset", obs1, mk(0,0,0,RNOP,0,0,0,0,0));
        step(0, BREL, 0, 1);
        check("d1_brel_miss", obs1, mk(1,0,0,RNOP,0,0,0,0,0));
        step(0, MULI, 0, 0);
        check("d1_muli", obs1, mk(1,0,0,RMUL,1,1,0,0,0));
        step(0, BREL, 1, 1);
        check("d1_brel_hit", obs1, mk(0,0,1,RNOP,0,0,0,0,0));
        step(0, MUL, 0, 0);
        check("d1_mul", obs1, mk(1,0,0,RMUL,0,1,0,0,0));

        // Random phase against the reference model, both instances.
        step(1, NOP, 0, 0);
        k0 = 0; k1 = 0; cur0 = NOP; cur1 = NOP;
        for (int n = 0; n < 800; n++) begin
            r_r   = ($urandom_range(0, 49) == 0);
            op_r  = 6'($urandom_range(0, 10));
            rdy_r = ($urandom_range(0, 3) == 0);
            bc_r  = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                rdy_r = 1'($urandom);
                bc_r  = 1'($urandom);
            end
            step(r_r, op_r, rdy_r, bc_r);
            e0 = model(k0, (k0 == 0) ? op_r : cur0, rdy_r, bc_r, r_r, 3, 1, d0);
            e1 = model(k1, (k1 == 0) ? op_r : cur1, rdy_r, bc_r, r_r, 1, 0, d1);
            check($sformatf("rand0_%0d", n), obs0, e0);
            check($sformatf("rand1_%0d", n), obs1, e1);
            if (r_r || d0) k0 = 0;
            else begin
                if (k0 == 0) cur0 = op_r;
                k0++;
            end
            if (r_r || d1) k1 = 0;
            else begin
                if (k1 == 0) cur1 = op_r;
                k1++;
            end
        end

        @(negedge clock);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
